dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two bus masters: M0 = Core, M1 = UART boot loader / DMA.
//  Sits between the masters and the DMemory wrapper, in place of the direct core-to-DMemory connection.
//  Serialises one transaction at a time, waits for DMemory read_valid and returns data plus a one-cycle ack.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data width; write mask is DATA_W/8 bits
//  TIMEOUT_CYCLES  255  max read wait before error completion; 0 = wait forever
// PORTS
//  clk             in   1        single clock
//  rst             in   1        synchronous reset, active-low (0 = reset)
//  mN_req          in   1        N=0,1: request; hold, with command stable, until mN_ack
//  mN_we           in   1        1 = write, 0 = read
//  mN_addr         in   ADDR_W   byte address
//  mN_wdata        in   DATA_W   write data
//  mN_wmask        in   DATA_W/8 byte-lane write mask
//  mN_ack          out  1        1-cycle completion pulse
//  mN_rdata        out  DATA_W   read data, valid when mN_ack=1
//  mN_err          out  1        read timeout, valid when mN_ack=1
//  s_address       out  ADDR_W   to DMemory
//  s_write_data    out  DATA_W
//  s_write_mask    out  DATA_W/8
//  s_write_enable  out  1
//  s_read_enable   out  1
//  s_read_data     in   DATA_W   from DMemory
//  s_read_valid    in   1
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - FSM goes to IDLE; all outputs become 0; the timeout counter clears.
//   - last_owner clears to M1, so M0 wins the first tie.
//   - If reset hits mid-transaction, the transaction is dropped and no ack is issued.
//  FSM states: IDLE -> ISSUE -> {WAIT_RD} -> DONE -> IDLE.
//  IDLE: req is sampled only in this state.
//   - If any request is present, pick a winner and latch owner, we, addr, wdata and wmask; go to ISSUE.
//  ISSUE: s_* are driven from the latched values.
//   - Write: s_write_enable=1 for exactly this cycle; go to DONE.
//   - Read: s_read_enable=1.
//     - If s_read_valid=1 in this cycle, capture s_read_data and go to DONE.
//     - Otherwise go to WAIT_RD.
//  WAIT_RD: s_read_enable is held at 1; the counter increments each cycle.
//   - On s_read_valid=1: capture data, go to DONE. Valid wins if it coincides with the timeout.
//   - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): rdata=0, err=1, go to DONE.
//  DONE:
//   - owner's ack=1 for one cycle, with rdata and err driven.
//   - All s_* enables are 0; last_owner is updated; go to IDLE.
//   - The non-owner's ack, rdata and err stay 0.
//  s_address, s_write_data and s_write_mask hold their last latched value outside ISSUE/WAIT_RD.
//  Throughput: write = 3 cycles per transaction; read = 3 + wait cycles.
//   - If a master keeps req=1 after its ack, that is a new request, arbitrated in the next IDLE.
//  Write with mask 0: still issued and acked.
//  Read data is passed through unmodified; byte extraction is done by the master.
//  Counter width: $clog2(TIMEOUT_CYCLES+1); the counter never wraps.
// CONFIGURATION
//  DMEM_ARB_RR_EN
//   - Defined: round-robin. When both request, the master that is not last_owner wins.
//   - Undefined: fixed priority, M0 always wins; last_owner is still tracked but unused.
// STRUCTURE
//  Package dmem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} arb_state_t;
//   - typedef enum logic {OWNER_M0, OWNER_M1} owner_t;
//  Sub-module dmem_arb_picker: combinational winner select, taking (req0, req1, last_owner) to owner_t.
//   - The DMEM_ARB_RR_EN macro is confined to this sub-module.
// TESTING
//  1. Reset: rst=0 for 2 cycles with both req=1 -> all outputs 0, no ack; first grant after release goes to M0.
//  2. M0 writes addr 0x90000010, data 0xDEADBEEF, mask 0xF:
//     -> s_write_enable=1 for 1 cycle with matching address/data; m0_ack 2 cycles after IDLE sampled req.
//  3. M1 reads 0x90000010; slave returns valid 2 cycles after read_enable with 0xDEADBEEF:
//     -> m1_ack=1, m1_rdata=0xDEADBEEF, m1_err=0.
//  4. Both req continuously, 6 transactions:
//     -> RR_EN: grants M0,M1,M0,M1,M0,M1; without macro: six M0 grants, M1 starved.
//  5. Read with s_read_valid never asserted, TIMEOUT_CYCLES=4:
//     -> ack with err=1 and rdata=0 after 4 WAIT_RD cycles; valid arriving on the 4th wait cycle -> err=0.
//  6. rst=0 during WAIT_RD -> no ack; s_read_enable=0 next cycle; new request served normally afterwards.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_M0,
    OWNER_M1
  } owner_t;

endpackage

// File: rtl/dmem_arb_picker.sv
// Combinational winner select between the two bus masters.
// Build option DMEM_ARB_RR_EN: defined = round-robin on ties,
// undefined = fixed priority with M0 always winning ties.
module dmem_arb_picker
  import dmem_arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_owner,
  output owner_t winner
);

  // Pick the owner for the next transaction from the current requests.
  always_comb begin
    winner = OWNER_M0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      winner = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
`else
      winner = OWNER_M0;
`endif
    end else if (req1) begin
      winner = OWNER_M1;
    end
  end

`ifndef DMEM_ARB_RR_EN
  // last_owner is still tracked by the parent but has no effect here.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between M0 (core) and M1 (boot loader/DMA).
// One transaction at a time: IDLE -> ISSUE -> [WAIT_RD] -> DONE -> IDLE.
// Arbitration policy selected by DMEM_ARB_RR_EN (see dmem_arb_picker).
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,

  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_write_data,
  output logic [DATA_W/8-1:0] s_write_mask,
  output logic                s_write_enable,
  output logic                s_read_enable,
  input  logic [DATA_W-1:0]   s_read_data,
  input  logic                s_read_valid
);

  localparam int unsigned MASK_W = DATA_W / 8;
  // A zero timeout still needs a 1-bit counter; it just saturates.
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_owner_q, last_owner_d;
  owner_t              winner;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;

  dmem_arb_picker u_picker (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  // State and latched-command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_M0;
      last_owner_q <= OWNER_M1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Saturating increment so the wait counter never wraps when timeout is off.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    cnt_d          = '0;

    m0_ack         = 1'b0;
    m0_rdata       = '0;
    m0_err         = 1'b0;
    m1_ack         = 1'b0;
    m1_rdata       = '0;
    m1_err         = 1'b0;
    s_address      = addr_q;
    s_write_data   = wdata_q;
    s_write_mask   = wmask_q;
    s_write_enable = 1'b0;
    s_read_enable  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = winner;
          if (winner == OWNER_M1) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wmask_d = m1_wmask;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wmask_d = m0_wmask;
          end
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          s_write_enable = 1'b1;
          state_d        = DONE;
        end else begin
          s_read_enable = 1'b1;
          if (s_read_valid) begin
            rdata_d = s_read_data;
            state_d = DONE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end

      WAIT_RD: begin
        s_read_enable = 1'b1;
        cnt_d         = cnt_inc;
        // Valid data takes precedence over a timeout in the same cycle.
        if (s_read_valid) begin
          rdata_d = s_read_data;
          state_d = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_CNT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (owner_q == OWNER_M1) begin
          m1_ack   = 1'b1;
          m1_rdata = rdata_q;
          m1_err   = err_q;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = rdata_q;
          m0_err   = err_q;
        end
        last_owner_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
